// File: rtl/gpio_apb_slave.sv
// gpio_apb_slave: APB completer that decodes a small word-register window and forwards accesses as single-cycle strobes.
//
// Optional macro GPIO_APB_PROT_CHECK_EN: when defined, writes with pprot_i[0]=0 are rejected with an error response.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   psel_i, penable_i, pwrite_i APB control
//   paddr_i, pwdata_i, pstrb_i  APB byte address, write data, byte strobes
//   pprot_i                     APB protection (used only with GPIO_APB_PROT_CHECK_EN)
//   prdata_o, pready_o          read data, transfer complete
//   pslverr_o                   error response
//   reg_addr_o                  decoded word index
//   reg_wdata_o, reg_wstrb_o    write data and strobes forwarded to the register block
//   reg_wen_o, reg_ren_o        single-cycle register write/read strobes
//   reg_rdata_i                 register read data, valid RD_LAT cycles after reg_ren_o
//   err_cnt_o                   saturating count of error responses
module gpio_apb_slave #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [AW-1:0]           paddr_i,
    input  logic [DW-1:0]           pwdata_i,
    input  logic [3:0]              pstrb_i,
    input  logic [2:0]              pprot_i,
    output logic [DW-1:0]           prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [$clog2(NREG)-1:0] reg_addr_o,
    output logic [DW-1:0]           reg_wdata_o,
    output logic [3:0]              reg_wstrb_o,
    output logic                    reg_wen_o,
    output logic                    reg_ren_o,
    input  logic [DW-1:0]           reg_rdata_i,
    output logic [7:0]              err_cnt_o
);
    localparam int ABITS = $clog2(NREG);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;
    localparam logic [2:0] LOAD    = 3'(RD_LAT > 0 ? RD_LAT - 1 : 0);

    logic [0:0] state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       first, bad, prot_err;
    logic       ready, slverr, wen, ren, rd_done;

`ifdef GPIO_APB_PROT_CHECK_EN
    assign prot_err = pwrite_i & ~pprot_i[0];
    logic unused_prot;
    assign unused_prot = ^pprot_i[2:1];
`else
    assign prot_err = 1'b0;
    logic unused_prot;
    assign unused_prot = ^pprot_i;
`endif

    assign first = (state == IDLE) & psel_i & penable_i;
    // NREG is a power of two, so any set bit above the index field is out of range
    assign bad   = (paddr_i[1:0] != 2'b00) | (|paddr_i[AW-1:ABITS+2]) | prot_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        slverr    = 1'b0;
        wen       = 1'b0;
        ren       = 1'b0;
        rd_done   = 1'b0;
        if (state == IDLE) begin
            if (first) begin
                if (bad) begin
                    ready  = 1'b1;
                    slverr = 1'b1;
                end else if (pwrite_i) begin
                    ready = 1'b1;
                    wen   = |pstrb_i;
                end else begin
                    ren = 1'b1;
                    if (RD_LAT == 0) begin
                        ready   = 1'b1;
                        rd_done = 1'b1;
                    end else begin
                        state_nxt = RD_WAIT;
                        cnt_nxt   = LOAD;
                    end
                end
            end
        end else if (!psel_i) begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
        end else if (cnt != 3'd0) begin
            cnt_nxt = cnt - 3'd1;
        end else begin
            ready     = 1'b1;
            rd_done   = 1'b1;
            state_nxt = IDLE;
        end
    end

    // Outputs are combinational, so gate them with rst to keep them quiet during reset
    assign pready_o    = ready & ~rst;
    assign pslverr_o   = slverr & ~rst;
    assign reg_wen_o   = wen & ~rst;
    assign reg_ren_o   = ren & ~rst;
    assign prdata_o    = (rd_done & ~pwrite_i & ~rst) ? reg_rdata_i : '0;
    assign reg_addr_o  = paddr_i[ABITS+1:2];
    assign reg_wdata_o = pwdata_i;
    assign reg_wstrb_o = pstrb_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            err_cnt_o <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pslverr_o && err_cnt_o != 8'hFF)
                err_cnt_o <= err_cnt_o + 8'd1;
        end
    end
endmodule

// File: tb/tb_gpio_apb_slave.sv
// tb_gpio_apb_slave: self-checking bench for gpio_apb_slave with RD_LAT=3, NREG=16.
module tb_gpio_apb_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = 3'b001;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [3:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_wen_o, reg_ren_o;
    logic [31:0] reg_rdata_i;
    logic [7:0]  err_cnt_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gpio_apb_slave #(.AW(32), .DW(32), .NREG(16), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
        .reg_wen_o(reg_wen_o), .reg_ren_o(reg_ren_o), .reg_rdata_i(reg_rdata_i),
        .err_cnt_o(err_cnt_o)
    );

    // Register block model: byte-strobed writes, read data presented exactly 3 cycles after reg_ren_o
    logic [31:0] mem [16];
    logic [2:0]  rpipe = '0;
    logic [3:0]  a0 = '0, a1 = '0, a2 = '0;
    always @(posedge clk) begin
        rpipe <= {rpipe[1:0], reg_ren_o};
        a0 <= reg_addr_o;
        a1 <= a0;
        a2 <= a1;
        if (reg_wen_o)
            for (int b = 0; b < 4; b++)
                if (reg_wstrb_o[b]) mem[reg_addr_o][8*b +: 8] <= reg_wdata_o[8*b +: 8];
    end
    assign reg_rdata_i = rpipe[2] ? mem[a2] : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [2:0] prot,
                        output logic err, output logic [31:0] rdata, output int waits,
                        output int wens, output int rens, output logic [3:0] waddr,
                        output logic viol);
        logic done;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pstrb = strb; pwdata = wdata; pprot = prot;
        @(negedge clk);
        viol = pready_o | pslverr_o | reg_wen_o | reg_ren_o;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; wens = 0; rens = 0; waddr = '0; done = 1'b0; err = 1'b0; rdata = '0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            wens += int'(reg_wen_o);
            rens += int'(reg_ren_o);
            if (reg_wen_o) waddr = reg_addr_o;
            if (pready_o) begin
                done = 1'b1; err = pslverr_o; rdata = prdata_o;
            end else begin
                waits++;
                if (prdata_o != 32'd0 || pslverr_o) viol = 1'b1;
            end
        end
        if (!done) chk("pready_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_check(input logic [7:0] ecnt);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {28'd0, pready_o, pslverr_o, reg_wen_o, reg_ren_o}, 32'd0);
        chk("err_cnt", {24'd0, err_cnt_o}, {24'd0, ecnt});
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          waits;
        int          wens;
        int          rens;
        logic [7:0]  ecnt;
    } vec_t;

    initial begin
        vec_t v [16];
        logic err, viol, seen;
        logic [31:0] rdata;
        logic [3:0] waddr;
        int waits, wens, rens;

        v[0]  = '{1, 32'h08,  4'hF, 32'hA5A50001, 0, 32'h0,        0, 1, 0, 8'd0};
        v[1]  = '{0, 32'h08,  4'hF, 32'h0,        0, 32'hA5A50001, 3, 0, 1, 8'd0};
        v[2]  = '{1, 32'h04,  4'hF, 32'h12345678, 0, 32'h0,        0, 1, 0, 8'd0};
        v[3]  = '{0, 32'h04,  4'h0, 32'h0,        0, 32'h12345678, 3, 0, 1, 8'd0};
        v[4]  = '{1, 32'h0C,  4'hF, 32'h11111111, 0, 32'h0,        0, 1, 0, 8'd0};
        v[5]  = '{1, 32'h0C,  4'h3, 32'hFFFFBEEF, 0, 32'h0,        0, 1, 0, 8'd0};
        v[6]  = '{0, 32'h0C,  4'h0, 32'h0,        0, 32'h1111BEEF, 3, 0, 1, 8'd0};
        v[7]  = '{1, 32'h10,  4'h0, 32'hFFFFFFFF, 0, 32'h0,        0, 0, 0, 8'd0};
        v[8]  = '{0, 32'h40,  4'h0, 32'h0,        1, 32'h0,        0, 0, 0, 8'd1};
        v[9]  = '{1, 32'h02,  4'hF, 32'h1,        1, 32'h0,        0, 0, 0, 8'd2};
        v[10] = '{1, 32'h3C,  4'hF, 32'hCAFEF00D, 0, 32'h0,        0, 1, 0, 8'd2};
        v[11] = '{0, 32'h3C,  4'h0, 32'h0,        0, 32'hCAFEF00D, 3, 0, 1, 8'd2};
        v[12] = '{0, 32'h41,  4'h0, 32'h0,        1, 32'h0,        0, 0, 0, 8'd3};
        v[13] = '{1, 32'h08,  4'h8, 32'h77000000, 0, 32'h0,        0, 1, 0, 8'd3};
        v[14] = '{0, 32'h08,  4'h0, 32'h0,        0, 32'h77A50001, 3, 0, 1, 8'd3};
        v[15] = '{1, 32'h100, 4'hF, 32'h5,        1, 32'h0,        0, 0, 0, 8'd4};

        // Reset held while an access is presented: everything must stay quiet
        psel = 1'b1; penable = 1'b1; paddr = 32'h4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pready", {31'd0, pready_o}, 32'd0);
        chk("rst_pslverr", {31'd0, pslverr_o}, 32'd0);
        chk("rst_strobes", {30'd0, reg_wen_o, reg_ren_o}, 32'd0);
        chk("rst_prdata", prdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            xfer(v[i].wr, v[i].addr, v[i].strb, v[i].wdata, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v[i].err});
            chk($sformatf("v%0d_waits", i), waits, v[i].waits);
            chk($sformatf("v%0d_wens", i), wens, v[i].wens);
            chk($sformatf("v%0d_rens", i), rens, v[i].rens);
            chk($sformatf("v%0d_viol", i), {31'd0, viol}, 32'd0);
            if (!v[i].err && !v[i].wr) chk($sformatf("v%0d_rdata", i), rdata, v[i].rdata);
            if (v[i].wr) chk($sformatf("v%0d_rdata_wr", i), rdata, 32'd0);
            if (v[i].wens != 0) chk($sformatf("v%0d_waddr", i), {28'd0, waddr}, {28'd0, v[i].addr[5:2]});
            idle_check(v[i].ecnt);
        end

        // Abort: psel dropped during RD_WAIT
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("abort_ren", {31'd0, reg_ren_o}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= pready_o | pslverr_o | reg_ren_o | reg_wen_o;
        end
        chk("abort_quiet", {31'd0, seen}, 32'd0);
        xfer(0, 32'h08, 4'h0, 32'h0, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
        chk("after_abort_rdata", rdata, 32'h77A50001);
        chk("after_abort_waits", waits, 3);

        // Back-to-back write then read with no idle cycle
        xfer(1, 32'h30, 4'hF, 32'hABCD0123, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
        chk("b2b_wr_err", {31'd0, err}, 32'd0);
        chk("b2b_wr_wens", wens, 1);
        chk("b2b_wr_addr", {28'd0, waddr}, 32'd12);
        xfer(0, 32'h30, 4'h0, 32'h0, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
        chk("b2b_rd_rdata", rdata, 32'hABCD0123);
        chk("b2b_rd_waits", waits, 3);
        chk("b2b_rd_viol", {31'd0, viol}, 32'd0);
        idle_check(8'd4);

        // Error counter saturation
        for (int i = 0; i < 260; i++)
            xfer(1, 32'h2, 4'hF, 32'h0, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
        chk("sat_last_err", {31'd0, err}, 32'd1);
        idle_check(8'd255);
        @(negedge clk);
        chk("sat_hold", {24'd0, err_cnt_o}, 32'd255);

        // Reset during the second RD_WAIT cycle
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdwait_pready", {31'd0, pready_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen |= pready_o | pslverr_o | reg_ren_o | reg_wen_o;
        end
        chk("rst_rdwait_quiet", {31'd0, seen}, 32'd0);
        chk("rst_rdwait_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        xfer(0, 32'h04, 4'h0, 32'h0, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
        chk("post_rst_rdata", rdata, 32'h12345678);
        chk("post_rst_waits", waits, 3);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        idle_check(8'd0);

        // Protection check on writes
        xfer(1, 32'h08, 4'hF, 32'h0BADF00D, 3'b000, err, rdata, waits, wens, rens, waddr, viol);
`ifdef GPIO_APB_PROT_CHECK_EN
        chk("prot0_err", {31'd0, err}, 32'd1);
        chk("prot0_wens", wens, 0);
        idle_check(8'd1);
`else
        chk("prot0_err", {31'd0, err}, 32'd0);
        chk("prot0_wens", wens, 1);
        idle_check(8'd0);
`endif
        xfer(1, 32'h08, 4'hF, 32'h600D0001, 3'b001, err, rdata, waits, wens, rens, waddr, viol);
        chk("prot1_err", {31'd0, err}, 32'd0);
        chk("prot1_wens", wens, 1);
        xfer(0, 32'h08, 4'h0, 32'h0, 3'b000, err, rdata, waits, wens, rens, waddr, viol);
        chk("prot_rd_err", {31'd0, err}, 32'd0);
        chk("prot_rd_rdata", rdata, 32'h600D0001);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
